ghash_byte_mult: RTL and testbench

Byte-serial GF(2^128) GHASH multiply-accumulate stage. It sits directly downstream of the combinational M0 table generator and consumes that generator's 129-entry H-multiple table. Each accepted 128-bit block X is folded into the running digest as Y ← (Y ⊕ X)·H, one byte per cycle, using Shoup's method with on-the-fly reduction. It feeds the GCM tag logic.

---
 rtl/ghash_byte_mult_pkg.sv | 44 ++++
 rtl/ghash_xpow8_reduce.sv | 29 ++
 rtl/ghash_byte_mult.sv | 119 +++++++++++
 tb/tb_ghash_byte_mult.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghash_byte_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_byte_mult_pkg
//  Description : Shared widths, reduction constant, FSM encoding and the
//                M0 table lookup helper for the byte-serial GHASH stage.
//                N_STEPS follows GHASH_BYTE_MULT_2BYTE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package ghash_byte_mult_pkg;

  localparam int NB_DATA  = 128;
  localparam int NB_BYTE  = 8;
  localparam int NB_TABLE = NB_DATA * (NB_DATA + 1);

  // x^128 = 1 + x + x^2 + x^7, written in GCM bit order (bit 127 = x^0)
  localparam logic [NB_DATA-1:0] R_X = {8'hE1, 120'd0};

`ifdef GHASH_BYTE_MULT_2BYTE_EN
  localparam int N_STEPS = 8;
`else
  localparam int N_STEPS = 16;
`endif
  localparam int NB_CNT = $clog2(N_STEPS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Byte-indexed H-multiple lookup. The top bit is folded in through entry
  // 128 (= H) so byte 8'h80 resolves to H ^ entry 0 = H.
  function automatic logic [NB_DATA-1:0] m0_lookup(
    input logic [NB_TABLE-1:0] tbl,
    input logic [NB_BYTE-1:0]  b
  );
    logic [NB_DATA-1:0] lo;
    lo = tbl[int'(b[6:0]) * NB_DATA +: NB_DATA];
    if (b[7]) begin
      return tbl[NB_DATA * NB_DATA +: NB_DATA] ^ lo;
    end
    return lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghash_xpow8_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_xpow8_reduce
//  Description : Combinational Z * x^8 mod P in GCM bit order: eight
//                right-shift steps, folding R_X back in whenever a set
//                x^127 coefficient falls off bit 0.
//  Revision    : 1.0  initial release
// ============================================================================
module ghash_xpow8_reduce
  import ghash_byte_mult_pkg::*;
(
  input  logic [NB_DATA-1:0] i_z,
  output logic [NB_DATA-1:0] o_z
);

  logic [NB_DATA-1:0] w_acc;

  // Unrolled multiply-by-x chain, one reduction decision per step
  always_comb begin
    w_acc = i_z;
    for (int i = 0; i < NB_BYTE; i++) begin
      w_acc = {1'b0, w_acc[NB_DATA-1:1]} ^ (w_acc[0] ? R_X : '0);
    end
  end

  assign o_z = w_acc;

endmodule
`default_nettype wire

// File: rtl/ghash_byte_mult.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_byte_mult
//  Description : Byte-serial GHASH multiply-accumulate, Y <= (Y ^ X) * H,
//                using Shoup's 8-bit table method with on-the-fly reduction.
//                Lowest byte of the block (highest-degree coefficients) is
//                consumed first so the Horner recurrence closes in 16 steps.
//                Define GHASH_BYTE_MULT_2BYTE_EN for a two-byte-per-cycle
//                datapath (8 steps); results are identical.
//  Revision    : 1.0  initial release
// ============================================================================
module ghash_byte_mult
  import ghash_byte_mult_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_TABLE-1:0] i_table,
  input  logic [NB_DATA-1:0]  i_x,
  input  logic                i_sof,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [NB_DATA-1:0]  o_ghash,
  output logic                o_valid
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_z;
  logic [NB_DATA-1:0] r_y;
  logic [NB_CNT-1:0]  r_cnt;
  logic               w_ready;
  logic               w_accept;
  logic               w_last;
  logic [NB_DATA-1:0] w_sh0;
  logic [NB_DATA-1:0] w_z_next;

  assign w_accept = i_valid & w_ready;
  assign w_last   = (r_cnt == NB_CNT'(N_STEPS - 1));

  ghash_xpow8_reduce u_shift0 (
    .i_z (r_z),
    .o_z (w_sh0)
  );

`ifdef GHASH_BYTE_MULT_2BYTE_EN
  logic [NB_BYTE-1:0] w_b_lo;
  logic [NB_BYTE-1:0] w_b_hi;
  logic [NB_DATA-1:0] w_mid;
  logic [NB_DATA-1:0] w_sh1;

  assign w_b_lo = r_a[{r_cnt, 4'b0000} +: NB_BYTE];
  assign w_b_hi = r_a[{r_cnt, 4'b1000} +: NB_BYTE];
  assign w_mid  = w_sh0 ^ m0_lookup(i_table, w_b_lo);

  ghash_xpow8_reduce u_shift1 (
    .i_z (w_mid),
    .o_z (w_sh1)
  );

  assign w_z_next = w_sh1 ^ m0_lookup(i_table, w_b_hi);
`else
  logic [NB_BYTE-1:0] w_b;

  assign w_b      = r_a[{r_cnt, 3'b000} +: NB_BYTE];
  assign w_z_next = w_sh0 ^ m0_lookup(i_table, w_b);
`endif

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: one block in flight, DONE lasts exactly one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)   w_state_next = ST_DONE;
      ST_DONE:               w_state_next = ST_IDLE;
      default:               w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state
  always_comb begin
    w_ready = (r_state == ST_IDLE);
    o_valid = (r_state == ST_DONE);
  end

  assign o_ready = w_ready;
  assign o_ghash = r_y;

  // Datapath: load the operand on accept, then one Horner step per RUN cycle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_a   <= '0;
      r_z   <= '0;
      r_y   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= i_sof ? i_x : (i_x ^ r_y);
      r_z   <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_z   <= w_z_next;
      r_cnt <= r_cnt + NB_CNT'(1);
      if (w_last) begin
        r_y <= w_z_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ghash_byte_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghash_byte_mult
//  Description : Self-checking bench for ghash_byte_mult. Expected digests
//                come from a bit-serial GF(2^128) reference multiplier and
//                are queued at accept time, popped when o_valid pulses.
//                Works with or without GHASH_BYTE_MULT_2BYTE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ghash_byte_mult;

`ifdef GHASH_BYTE_MULT_2BYTE_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif
  localparam int NB_TBL = 128 * 129;
  localparam logic [127:0] C_R     = {8'hE1, 120'd0};
  localparam logic [127:0] C_H     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C_ONE   = 128'h80000000000000000000000000000000;
  localparam logic [127:0] C_TC2B1 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] C_TC2Y1 = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] C_TC2B2 = 128'h00000000000000000000000000000080;
  localparam logic [127:0] C_TC2Y2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB_TBL-1:0] tbl_in = '0;
  logic [127:0]      x_in = '0;
  logic              sof_in = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [127:0]      ghash_out;
  logic              valid_out;

  int                n_checks = 0;
  int                n_pass = 0;
  logic [127:0]      m_y = '0;
  logic [127:0]      sb_q[$];

  ghash_byte_mult dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_table (tbl_in),
    .i_x     (x_in),
    .i_sof   (sof_in),
    .i_valid (valid_in),
    .o_ready (ready_out),
    .o_ghash (ghash_out),
    .o_valid (valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [127:0] mulx(input logic [127:0] v);
    return v[0] ? ((v >> 1) ^ C_R) : (v >> 1);
  endfunction

  // Reference multiply, one coefficient of a at a time starting at x^0
  function automatic logic [127:0] gf_mult(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = b;
    for (int i = 127; i >= 0; i--) begin
      if (a[i]) z = z ^ v;
      v = mulx(v);
    end
    return z;
  endfunction

  task automatic build_table(input logic [127:0] h);
    logic [127:0] e [0:128];
    logic [127:0] p;
    logic [127:0] acc;
    p = h;
    e[128] = h;
    for (int j = 1; j < 8; j++) begin
      p = mulx(p);
      e[128 >> j] = p;
    end
    e[0] = '0;
    for (int k = 1; k < 128; k++) begin
      acc = '0;
      for (int t = 0; t < 7; t++) if (k[t]) acc = acc ^ e[1 << t];
      e[k] = acc;
    end
    for (int k = 0; k <= 128; k++) tbl_in[k*128 +: 128] = e[k];
  endtask

  // Drive one block from idle and check latency, digest and pulse width
  task automatic run_block(input logic [127:0] x, input logic sof,
                           input logic [127:0] exp, input string name);
    int           cyc;
    bit           seen;
    logic [127:0] want;
    @(negedge clk);
    n_checks++;
    if (ready_out !== 1'b1) $display("FAIL %s ready_idle got %b want 1", name, ready_out);
    else n_pass++;
    x_in = x; sof_in = sof; valid_in = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    valid_in = 1'b0;
    n_checks++;
    if (ready_out !== 1'b0) $display("FAIL %s ready_busy got %b want 0", name, ready_out);
    else n_pass++;
    cyc = 1; seen = 0;
    while (!seen && cyc <= LAT + 4) begin
      if (valid_out === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (!seen || cyc != LAT) $display("FAIL %s latency got %0d want %0d", name, cyc, LAT);
    else n_pass++;
    want = sb_q.pop_front();
    n_checks++;
    if (!seen || ghash_out !== want) $display("FAIL %s digest got %h want %h", name, ghash_out, want);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1)
      $display("FAIL %s after_done valid=%b ready=%b want valid=0 ready=1", name, valid_out, ready_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || ghash_out !== 128'd0)
      $display("FAIL reset_values ready=%b valid=%b ghash=%h want 1 0 0", ready_out, valid_out, ghash_out);
    else n_pass++;
    m_y = '0;
    build_table(C_H);
    run_block(128'd0, 1'b1, 128'd0, "zero_block");
  endtask

  task automatic test_identity();
    run_block(C_ONE, 1'b1, C_H, "identity");
    m_y = C_H;
  endtask

  task automatic test_gcm_tc2();
    run_block(C_TC2B1, 1'b1, C_TC2Y1, "tc2_block1");
    run_block(C_TC2B2, 1'b0, C_TC2Y2, "tc2_block2");
    run_block(C_TC2B1, 1'b1, C_TC2Y1, "sof_discard");
    m_y = C_TC2Y1;
  endtask

  task automatic test_back_to_back();
    int           since_acc;
    int           n_drive;
    int           total;
    bit           exp_ready;
    bit           exp_valid;
    logic [127:0] h;
    logic [127:0] blk;
    logic [127:0] want;
    h = {$urandom(), $urandom(), $urandom(), $urandom()};
    build_table(h);
    since_acc = LAT + 1;
    n_drive   = 3 * (LAT + 1);
    total     = n_drive + LAT + 2;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      exp_ready = (since_acc > LAT);
      exp_valid = (since_acc == LAT);
      n_checks++;
      if (ready_out !== exp_ready) $display("FAIL b2b_ready cyc%0d got %b want %b", i, ready_out, exp_ready);
      else n_pass++;
      n_checks++;
      if (valid_out !== exp_valid) $display("FAIL b2b_valid cyc%0d got %b want %b", i, valid_out, exp_valid);
      else n_pass++;
      if (valid_out === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL b2b_digest cyc%0d got %h want none", i, ghash_out);
        else begin
          want = sb_q.pop_front();
          if (ghash_out !== want) $display("FAIL b2b_digest cyc%0d got %h want %h", i, ghash_out, want);
          else n_pass++;
        end
      end
      if (i < n_drive) begin
        x_in     = {$urandom(), $urandom(), $urandom(), $urandom()};
        sof_in   = (i == 0) || ($urandom_range(0, 3) == 0);
        valid_in = 1'b1;
        if (exp_ready) begin
          blk = sof_in ? x_in : (x_in ^ m_y);
          m_y = gf_mult(blk, h);
          sb_q.push_back(m_y);
          since_acc = 1;
        end else begin
          since_acc++;
        end
      end else begin
        valid_in = 1'b0;
        since_acc++;
      end
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL b2b_drain got %0d pending want 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit           seen;
    logic [127:0] x2;
    build_table(C_H);
    @(negedge clk);
    x_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    sof_in = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || ghash_out !== 128'd0)
      $display("FAIL midrun_reset ready=%b valid=%b ghash=%h want 1 0 0", ready_out, valid_out, ghash_out);
    else n_pass++;
    seen = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (valid_out === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen) $display("FAIL midrun_no_valid got pulse want none");
    else n_pass++;
    m_y = '0;
    x2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block(x2, 1'b0, gf_mult(x2 ^ m_y, C_H), "after_reset");
    m_y = gf_mult(x2, C_H);
  endtask

  task automatic test_reset_vs_accept();
    bit seen;
    @(negedge clk);
    x_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    sof_in = 1'b1; valid_in = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    n_checks++;
    if (ready_out !== 1'b1 || ghash_out !== 128'd0)
      $display("FAIL reset_wins ready=%b ghash=%h want 1 0", ready_out, ghash_out);
    else n_pass++;
    seen = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (valid_out === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen) $display("FAIL reset_wins_no_valid got pulse want none");
    else n_pass++;
    m_y = '0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_gcm_tc2();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_vs_accept();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
